// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, types and helpers for the pipeline controller.
// Stall vector bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
package pipeline_ctrl_pkg;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef logic [31:0] exc_type_t;
  localparam exc_type_t EXC_DEFAULT = 32'h0000_0000;
  localparam exc_type_t EXC_ERET    = 32'h0000_000E;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_t;

  // The deepest requesting stage wins; it also freezes every stage upstream of it.
  function automatic stall_bus_t stall_from_req(logic rq_if, logic rq_id,
                                                logic rq_ex, logic rq_mem);
    if (rq_mem)     return STALL_MEM;
    else if (rq_ex) return STALL_EX;
    else if (rq_id) return STALL_ID;
    else if (rq_if) return STALL_IF;
    else            return STALL_NONE;
  endfunction

  function automatic logic [31:0] redirect_pc(exc_type_t exc_type, logic [31:0] epc,
                                              logic [31:0] vector);
    return (exc_type == EXC_ERET) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall request / exception / stall-flush bundle between the pipeline and its controller.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic       stallreq_if;
  logic       stallreq_id;
  logic       stallreq_ex;
  logic       stallreq_mem;
  exc_type_t  mem_exception_type;
  logic [31:0] cp0_epc;
  stall_bus_t stall;
  logic       flush;
  logic [31:0] new_pc;
  logic       exc_pending;

  modport master (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mem_exception_type, cp0_epc,
    output stall, flush, new_pc, exc_pending
  );

  modport slave (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mem_exception_type, cp0_epc,
    input  stall, flush, new_pc, exc_pending
  );
endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Saturating count of consecutive PC-stalled cycles with a sticky timeout flag.
module stall_watchdog #(
  parameter int WDOG_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc,
  output logic stall_timeout
);

  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WDOG_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d = '0;
    if (stall_pc) cnt_d = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + CNT_W'(1);
    // Flag sets on the same edge the count reaches the limit, then sticks.
    timeout_d = timeout_q | (cnt_d == LIMIT_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Merges stage stall requests and turns MEM exceptions into flush + redirect PC.
// Optional perf counters are enabled with the PIPELINE_CTRL_PERF_EN macro.
//
// state      | meaning
// ST_IDLE    | no exception held; stall follows requests, bus-idle exceptions flush at once
// ST_PENDING | exception latched while the data bus is busy; flush when it completes
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          WDOG_LIMIT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.master bus,
  output logic           stall_timeout
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_stall_cycles,
  output logic [31:0]    perf_flush_count
`endif
);

  state_t      state_q, state_d;
  exc_type_t   exc_type_q, exc_type_d;
  logic [31:0] epc_q, epc_d;
  stall_bus_t  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;

  always_comb begin
    state_d    = state_q;
    exc_type_d = exc_type_q;
    epc_d      = epc_q;
    stall_c    = STALL_NONE;
    flush_c    = 1'b0;
    new_pc_c   = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_exception_type != EXC_DEFAULT) begin
          if (bus.stallreq_mem) begin
            exc_type_d = bus.mem_exception_type;
            epc_d      = bus.cp0_epc;
            state_d    = ST_PENDING;
            stall_c    = STALL_MEM;
          end else begin
            flush_c  = 1'b1;
            new_pc_c = redirect_pc(bus.mem_exception_type, bus.cp0_epc, EXC_VECTOR);
          end
        end else begin
          stall_c = stall_from_req(bus.stallreq_if, bus.stallreq_id,
                                   bus.stallreq_ex, bus.stallreq_mem);
        end
      end
      ST_PENDING: begin
        if (bus.stallreq_mem) begin
          stall_c = STALL_MEM;
        end else begin
          flush_c    = 1'b1;
          new_pc_c   = redirect_pc(exc_type_q, epc_q, EXC_VECTOR);
          state_d    = ST_IDLE;
          exc_type_d = EXC_DEFAULT;
          epc_d      = 32'h0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are forced quiet during reset so nothing downstream moves.
    if (rst) begin
      stall_c  = STALL_NONE;
      flush_c  = 1'b0;
      new_pc_c = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      exc_type_q <= EXC_DEFAULT;
      epc_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      exc_type_q <= exc_type_d;
      epc_q      <= epc_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush       = flush_c;
  assign bus.new_pc      = new_pc_c;
  assign bus.exc_pending = (state_q == ST_PENDING) && !rst;

  stall_watchdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_stall_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_pc     (stall_c[0]),
    .stall_timeout(stall_timeout)
  );

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + ((stall_c != STALL_NONE) ? 32'd1 : 32'd0);
    perf_flush_d = perf_flush_q + (flush_c ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule
